// File: rtl/tl_ram_responder_pkg.sv
// tl_ram_responder_pkg: shared TL channel types, opcode constants and the queued-response record.
// Provides tilelink_a / tilelink_d channel structs, the A/D opcode constants used by the
// RAM responder, and resp_t, the entry stored in the response FIFO.
package tl_ram_responder_pkg;
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tilelink_a;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
  } tilelink_d;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } resp_t;
  function automatic logic [2:0] resp_opcode(input logic [2:0] a_opcode);
    return (a_opcode == Get) ? AccessAckData : AccessAck;
  endfunction
endpackage

// File: rtl/tl_resp_fifo.sv
// tl_resp_fifo: circular response queue with wrap-around pointers and occupancy count.
// Ports: clock, reset_n (async active-low), push/din write an entry, pop retires head,
// head is the oldest entry, count is the current occupancy (0..DEPTH).
module tl_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // Popping an empty queue is a no-op; a push into a full queue is only taken when a pop frees the slot.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((int'(count) < DEPTH) | do_pop);
  assign head    = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TileLink-UL A->D responder in front of a single-cycle RAM.
// Ports: clock; reset_n (async active-low); tla A-channel request in; a_ready accept credit;
// ram_tla request forwarded to the RAM (a_valid gated by acceptance); rdata RAM read/merged
// word, valid the cycle after accept; tld D-channel response out; d_ready downstream consume.
// Option: define TL_RESP_ERROR_EN to flag out-of-range addresses and unknown opcodes with
// d_error and keep such requests away from the RAM.
module tl_ram_responder
  import tl_ram_responder_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ADDR_BITS = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  tilelink_a   tla,
  output logic        a_ready,
  output tilelink_a   ram_tla,
  input  logic [31:0] rdata,
  output tilelink_d   tld,
  input  logic        d_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic accept, err, pop, d_valid;
  logic pend_valid, pend_err;
  logic [2:0] pend_op;
  logic [1:0] pend_size;
  logic [7:0] pend_source;
  resp_t din, head;
`ifdef TL_RESP_ERROR_EN
  assign err = ((tla.a_address >> ADDR_BITS) != 32'd0) ||
               !(tla.a_opcode inside {Get, PutFullData, PutPartialData});
`else
  assign err = 1'b0;
`endif
  assign d_valid = count != '0;
  assign pop     = d_valid & d_ready;
  // Credit check counts the entry leaving this cycle so a full-rate stream never stalls.
  assign a_ready = reset_n & ((int'(count) + int'(pend_valid) - int'(pop)) < DEPTH);
  assign accept  = tla.a_valid & a_ready;
  always_comb begin
    ram_tla         = tla;
    ram_tla.a_valid = accept & ~err;
    ram_tla.d_ready = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pend_valid  <= 1'b0;
      pend_op     <= '0;
      pend_size   <= '0;
      pend_source <= '0;
      pend_err    <= 1'b0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_op     <= resp_opcode(tla.a_opcode);
        pend_size   <= tla.a_size;
        pend_source <= tla.a_source;
        pend_err    <= err;
      end
    end
  always_comb begin
    din.opcode = pend_op;
    din.size   = pend_size;
    din.source = pend_source;
    din.error  = pend_err;
    din.data   = (pend_op == AccessAckData && !pend_err) ? rdata : 32'd0;
  end
  tl_resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (pend_valid),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .count   (count)
  );
  // Fields are zero whenever nothing is queued, so reset and idle both present an all-zero D channel.
  always_comb begin
    tld = '0;
    if (d_valid) begin
      tld.d_valid  = 1'b1;
      tld.d_opcode = head.opcode;
      tld.d_size   = head.size;
      tld.d_source = head.source;
      tld.d_data   = head.data;
      tld.d_error  = head.error;
    end
  end
endmodule
